// File: rtl/command_pkg.sv
// Shared definitions for the CPLD command sequencer: command byte codes,
// line-select encoding, FSM state encoding and the request-to-code encoder.
package command_pkg;

  // Command byte codes driven on the CPLD command bus
  localparam logic [7:0] CMD_IDLE         = 8'h01;
  localparam logic [7:0] CMD_RESET_LO     = 8'h02;
  localparam logic [7:0] CMD_RESET_HI     = 8'h03;
  localparam logic [7:0] CMD_SREG_EN_LO   = 8'h04;
  localparam logic [7:0] CMD_SREG_EN_HI   = 8'h05;
  localparam logic [7:0] CMD_SI_LO        = 8'h06;
  localparam logic [7:0] CMD_SI_HI        = 8'h07;
  localparam logic [7:0] CMD_OE_LO        = 8'h08;
  localparam logic [7:0] CMD_OE_HI        = 8'h09;
  localparam logic [7:0] CMD_WE_LO        = 8'h0A;
  localparam logic [7:0] CMD_WE_HI        = 8'h0C;  // 0x0B is not a WE code on the CPLD
  localparam logic [7:0] CMD_COUNTER_LO   = 8'h0D;
  localparam logic [7:0] CMD_COUNTER_HI   = 8'h0E;
  localparam logic [7:0] CMD_SNES_MODE_LO = 8'h0F;
  localparam logic [7:0] CMD_SNES_MODE_HI = 8'h10;

  // Width of one queued request: {sel, level}
  localparam int REQ_W = 4;

  // CPLD control line selector
  typedef enum logic [2:0] {
    SEL_RESET     = 3'd0,
    SEL_SREG_EN   = 3'd1,
    SEL_SI        = 3'd2,
    SEL_OE        = 3'd3,
    SEL_WE        = 3'd4,
    SEL_COUNTER   = 3'd5,
    SEL_SNES_MODE = 3'd6,
    SEL_ILLEGAL   = 3'd7
  } sel_e;

  // Bus-cycle FSM states
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_STROBE = 2'd2,
    S_HOLD   = 2'd3
  } state_e;

  // One queued request
  typedef struct packed {
    sel_e sel;
    logic level;
  } req_t;

  // Table lookup from (line, level) to command byte; codes are not linear in sel.
  function automatic logic [7:0] encode_cmd(input sel_e sel, input logic level);
    logic [7:0] code;
    code = CMD_IDLE;
    case (sel)
      SEL_RESET:     code = level ? CMD_RESET_HI     : CMD_RESET_LO;
      SEL_SREG_EN:   code = level ? CMD_SREG_EN_HI   : CMD_SREG_EN_LO;
      SEL_SI:        code = level ? CMD_SI_HI        : CMD_SI_LO;
      SEL_OE:        code = level ? CMD_OE_HI        : CMD_OE_LO;
      SEL_WE:        code = level ? CMD_WE_HI        : CMD_WE_LO;
      SEL_COUNTER:   code = level ? CMD_COUNTER_HI   : CMD_COUNTER_LO;
      SEL_SNES_MODE: code = level ? CMD_SNES_MODE_HI : CMD_SNES_MODE_LO;
      default:       code = CMD_IDLE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Request queue for the command sequencer: synchronous FIFO with a registered
// occupancy count, first-word fall-through read data and async active-high reset.
module cmd_fifo
  import command_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = REQ_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // Flags come straight from the registered count, so a pop cannot reopen a full queue in the same cycle
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == {CNT_W{1'b0}});
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_rdata   = r_mem[r_rd_ptr];

  // Storage write and pointer/count bookkeeping; pointers wrap naturally since DEPTH is a power of 2
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {WIDTH{1'b0}};
      end
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/command_sequencer.sv
// AVR-side initiator for the CPLD 8-bit command bus. Queues line-level
// requests, encodes them and runs a setup/strobe/hold cycle per command,
// keeping a shadow of the last commanded level on each line.
// Optional feature macro: CMD_SHADOW_FILTER_EN (drop requests that match the shadow).
module command_sequencer
  import command_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 2
) (
  input  logic       avr_clk,
  input  logic       avr_rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_sel,
  input  logic       req_level,
  output logic [7:0] cmd_ctrl,
  output logic       cmd_clk,
  output logic       busy,
  output logic [6:0] shadow,
  output logic       err
);

  localparam int MAX_AB  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int MAX_CYC = (MAX_AB > HOLD_CYC) ? MAX_AB : HOLD_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [7:0]       r_cmd_ctrl;
  logic [7:0]       w_cmd_ctrl_nxt;
  logic             r_cmd_clk;
  logic             w_cmd_clk_nxt;
  logic [6:0]       r_shadow;
  logic [6:0]       w_shadow_nxt;
  req_t             r_cur;
  req_t             w_cur_nxt;
  logic             r_err;
  logic             w_err_nxt;

  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [REQ_W-1:0] w_rdata;
  req_t             w_head;
  logic             w_discard;
  logic             w_cyc_last;

  assign w_accept  = req_valid && !w_full;
  assign w_push    = w_accept && (req_sel != SEL_ILLEGAL);
  assign w_head    = req_t'(w_rdata);
  assign req_ready = !w_full;
  assign busy      = (r_state != S_IDLE) || !w_empty;
  assign cmd_ctrl  = r_cmd_ctrl;
  assign cmd_clk   = r_cmd_clk;
  assign shadow    = r_shadow;
  assign err       = r_err;

`ifdef CMD_SHADOW_FILTER_EN
  logic [7:0] w_shadow8;
  assign w_shadow8 = {1'b0, r_shadow};
  assign w_discard = (w_head.level == w_shadow8[w_head.sel]);
`else
  assign w_discard = 1'b0;
`endif

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (REQ_W)
  ) u_fifo (
    .i_clk   (avr_clk),
    .i_rst   (avr_rst),
    .i_push  (w_push),
    .i_wdata ({req_sel, req_level}),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Flag the last cycle of the current timed phase
  always_comb begin
    w_cyc_last = 1'b0;
    case (r_state)
      S_SETUP:  w_cyc_last = (r_cnt == SETUP_LAST);
      S_STROBE: w_cyc_last = (r_cnt == STROBE_LAST);
      S_HOLD:   w_cyc_last = (r_cnt == HOLD_LAST);
      default:  w_cyc_last = 1'b0;
    endcase
  end

  // Next-state logic: pop in idle, then walk setup/strobe/hold with a shared phase counter
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (w_discard) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_SETUP;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
        w_cnt_nxt = {CNT_W{1'b0}};
      end
      S_SETUP, S_STROBE, S_HOLD: begin
        if (w_cyc_last) begin
          w_cnt_nxt = {CNT_W{1'b0}};
          case (r_state)
            S_SETUP:  w_state_nxt = S_STROBE;
            S_STROBE: w_state_nxt = S_HOLD;
            default:  w_state_nxt = S_IDLE;
          endcase
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Output logic: next values of the bus, shadow and error pulse
  always_comb begin
    w_cmd_ctrl_nxt = r_cmd_ctrl;
    w_cmd_clk_nxt  = r_cmd_clk;
    w_shadow_nxt   = r_shadow;
    w_cur_nxt      = r_cur;
    case (r_state)
      S_IDLE: begin
        w_cmd_clk_nxt = 1'b0;
        if (w_pop && !w_discard) begin
          w_cmd_ctrl_nxt = encode_cmd(w_head.sel, w_head.level);
          w_cur_nxt      = w_head;
        end else begin
          w_cmd_ctrl_nxt = CMD_IDLE;
        end
      end
      S_SETUP: begin
        if (w_cyc_last) begin
          w_cmd_clk_nxt = 1'b1;
        end else begin
          w_cmd_clk_nxt = 1'b0;
        end
      end
      S_STROBE: begin
        if (w_cyc_last) begin
          w_cmd_clk_nxt = 1'b0;
        end else begin
          w_cmd_clk_nxt = 1'b1;
        end
      end
      S_HOLD: begin
        w_cmd_clk_nxt = 1'b0;
        if (w_cyc_last) begin
          w_cmd_ctrl_nxt          = CMD_IDLE;
          w_shadow_nxt[r_cur.sel] = r_cur.level;
        end else begin
          w_cmd_ctrl_nxt = r_cmd_ctrl;
        end
      end
      default: begin
        w_cmd_ctrl_nxt = CMD_IDLE;
        w_cmd_clk_nxt  = 1'b0;
      end
    endcase
    w_err_nxt = w_accept && (req_sel == SEL_ILLEGAL);
  end

  // State and output registers; reset forces the bus to IDLE immediately, even mid-transfer
  always_ff @(posedge avr_clk or posedge avr_rst) begin
    if (avr_rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= {CNT_W{1'b0}};
      r_cmd_ctrl <= CMD_IDLE;
      r_cmd_clk  <= 1'b0;
      r_shadow   <= 7'b000_0000;
      r_cur      <= '{sel: SEL_RESET, level: 1'b0};
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_cmd_ctrl <= w_cmd_ctrl_nxt;
      r_cmd_clk  <= w_cmd_clk_nxt;
      r_shadow   <= w_shadow_nxt;
      r_cur      <= w_cur_nxt;
      r_err      <= w_err_nxt;
    end
  end

endmodule
